// File: rtl/cpu_pkg.sv
// cpu_pkg: ISA encodings, ALU ops, memory sizes and pipeline-register layouts for cpu
package cpu_pkg;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_WORDS = 32;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_MEM = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SLL, ALU_SRA, ALU_MUL} alu_op_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    alu_op_e     op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } idex_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wdata;
  } exmem_t;
  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
  } memwb_t;
endpackage

// File: rtl/cpu_if.sv
// cpu_if: run control, instruction-memory load port and pipeline status of the cpu core
interface cpu_if;
  logic        start_i;
  logic        i_imem_we;
  logic [7:0]  i_imem_addr;
  logic [31:0] i_imem_wdata;
  logic [31:0] o_pc;
  logic        o_stall;
  logic        o_flush;
  logic        o_branch;
  modport master (output start_i, i_imem_we, i_imem_addr, i_imem_wdata, input o_pc, o_stall, o_flush, o_branch);
  modport slave (input start_i, i_imem_we, i_imem_addr, i_imem_wdata, output o_pc, o_stall, o_flush, o_branch);
endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational EX-stage ALU; multiplier present only with CPU_MUL_EN
module cpu_alu import cpu_pkg::*; (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_y
);
  logic [31:0] w_sra;
  assign w_sra = 32'($signed(i_a) >>> i_b[4:0]);
  // result select by operation
  always_comb
    o_y = i_op == ALU_SUB ? i_a - i_b :
          i_op == ALU_AND ? i_a & i_b :
          i_op == ALU_XOR ? i_a ^ i_b :
          i_op == ALU_SLL ? i_a << i_b[4:0] :
          i_op == ALU_SRA ? w_sra :
`ifdef CPU_MUL_EN
          i_op == ALU_MUL ? i_a * i_b :
`endif
          i_a + i_b;
endmodule

// File: rtl/cpu.sv
// cpu: five-stage RV32 subset pipeline with forwarding, hazards and ID-stage beq; mul via CPU_MUL_EN
module cpu import cpu_pkg::*; (
  input logic  clk_i,
  input logic  rst_i,
  cpu_if.slave bus
);
  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];
  logic [31:0] r_rf [32];
  logic [31:0] r_pc;
  ifid_t       r_ifid;
  idex_t       r_idex;
  exmem_t      r_exmem;
  memwb_t      r_memwb;
  logic        stall, flush, branch;
  logic [31:0] w_ins, w_rv1, w_rv2, w_ba, w_bb, w_target, w_wb_val, w_fa, w_fb, w_opb, w_alu_y, w_mem_rd;
  logic [6:0]  w_opc, w_f7;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_f3;
  logic        w_r, w_mul, w_addi, w_srai, w_lw, w_sw, w_beq, w_wb_we, w_ex_hit, w_mem_lw_hit, w_bstall, w_hold;
  alu_op_e     w_op;
  idex_t       w_dec;
  ifid_t       w_fetch;
  assign w_ins = r_ifid.instr;
  assign {w_f7, w_rs2, w_rs1, w_f3, w_rd, w_opc} = w_ins;
`ifdef CPU_MUL_EN
  assign w_mul = w_opc == OP_R && w_f7 == F7_MUL && w_f3 == F3_ADD;
`else
  assign w_mul = 1'b0;
`endif
  assign w_r = w_opc == OP_R && ((w_f7 == F7_BASE && (w_f3 == F3_ADD || w_f3 == F3_SLL || w_f3 == F3_XOR || w_f3 == F3_AND))
             || (w_f7 == F7_ALT && w_f3 == F3_ADD) || w_mul);
  assign w_addi = w_opc == OP_I && w_f3 == F3_ADD;
  assign w_srai = w_opc == OP_I && w_f3 == F3_SR && w_f7 == F7_ALT;
  assign w_lw = w_opc == OP_LW && w_f3 == F3_MEM;
  assign w_sw = w_opc == OP_SW && w_f3 == F3_MEM;
  assign w_beq = w_opc == OP_BEQ && w_f3 == F3_ADD;
  assign w_op = !w_r ? (w_srai ? ALU_SRA : ALU_ADD) : w_mul ? ALU_MUL : w_f7 == F7_ALT ? ALU_SUB :
                w_f3 == F3_AND ? ALU_AND : w_f3 == F3_XOR ? ALU_XOR : w_f3 == F3_SLL ? ALU_SLL : ALU_ADD;
  assign w_wb_we = r_memwb.reg_write && r_memwb.rd != 5'd0;
  assign w_wb_val = r_memwb.mem_to_reg ? r_memwb.mem : r_memwb.alu;
  assign w_rv1 = w_rs1 == 5'd0 ? '0 : w_wb_we && r_memwb.rd == w_rs1 ? w_wb_val : r_rf[w_rs1];
  assign w_rv2 = w_rs2 == 5'd0 ? '0 : w_wb_we && r_memwb.rd == w_rs2 ? w_wb_val : r_rf[w_rs2];
  assign w_ba = r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == w_rs1 ? r_exmem.alu : w_rv1;
  assign w_bb = r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == w_rs2 ? r_exmem.alu : w_rv2;
  assign w_target = r_ifid.pc + {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_ex_hit = r_idex.reg_write && r_idex.rd != 5'd0 && (r_idex.rd == w_rs1 || r_idex.rd == w_rs2);
  assign w_mem_lw_hit = r_exmem.mem_to_reg && r_exmem.rd != 5'd0 && (r_exmem.rd == w_rs1 || r_exmem.rd == w_rs2);
  assign branch = w_beq;
  assign w_bstall = w_beq && (w_ex_hit || w_mem_lw_hit);
  assign stall = !w_beq && r_idex.mem_to_reg && w_ex_hit;
  assign w_hold = stall || w_bstall;
  assign flush = w_beq && !w_bstall && w_ba == w_bb;
  assign w_fetch = '{pc: r_pc, instr: r_imem[r_pc[9:2]]};
  assign w_fa = r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == r_idex.rs1 ? r_exmem.alu :
                w_wb_we && r_memwb.rd == r_idex.rs1 ? w_wb_val : r_idex.a;
  assign w_fb = r_exmem.reg_write && r_exmem.rd != 5'd0 && r_exmem.rd == r_idex.rs2 ? r_exmem.alu :
                w_wb_we && r_memwb.rd == r_idex.rs2 ? w_wb_val : r_idex.b;
  assign w_opb = r_idex.alu_src ? r_idex.imm : w_fb;
  assign w_mem_rd = r_dmem[r_exmem.alu[6:2]];
  assign bus.o_pc = r_pc;
  assign bus.o_stall = stall;
  assign bus.o_flush = flush;
  assign bus.o_branch = branch;
  cpu_alu u_alu (.i_a(w_fa), .i_b(w_opb), .i_op(r_idex.op), .o_y(w_alu_y));
  // decode the IF/ID instruction into ID/EX controls; unknown encodings leave every control at 0
  always_comb begin
    w_dec = '0;
    w_dec.reg_write = w_r || w_addi || w_srai || w_lw;
    w_dec.mem_to_reg = w_lw;
    w_dec.mem_write = w_sw;
    w_dec.alu_src = w_addi || w_srai || w_lw || w_sw;
    w_dec.op = w_op;
    w_dec.rs1 = w_rs1;
    w_dec.rs2 = w_rs2;
    w_dec.rd = w_rd;
    w_dec.a = w_rv1;
    w_dec.b = w_rv2;
    w_dec.imm = {{20{w_ins[31]}}, w_f7, w_sw ? w_rd : w_rs2};
  end
  // PC and pipeline registers; hazards hold PC/IF-ID and bubble ID/EX
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_pc <= '0;
      r_ifid <= '0;
      r_idex <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_pc <= w_hold ? r_pc : flush ? w_target : bus.start_i ? r_pc + 32'd4 : r_pc;
      r_ifid <= w_hold ? r_ifid : (flush || !bus.start_i) ? '0 : w_fetch;
      r_idex <= w_hold ? '0 : w_dec;
      r_exmem <= '{reg_write: r_idex.reg_write, mem_to_reg: r_idex.mem_to_reg, mem_write: r_idex.mem_write,
                   rd: r_idex.rd, alu: w_alu_y, wdata: w_fb};
      r_memwb <= '{reg_write: r_exmem.reg_write, mem_to_reg: r_exmem.mem_to_reg, rd: r_exmem.rd,
                   alu: r_exmem.alu, mem: w_mem_rd};
    end
  // unreset storage: store, writeback (x0 never written) and program load
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_exmem.mem_write) r_dmem[r_exmem.alu[6:2]] <= r_exmem.wdata;
    if (!rst_i && w_wb_we) r_rf[r_memwb.rd] <= w_wb_val;
    if (bus.i_imem_we) r_imem[bus.i_imem_addr] <= bus.i_imem_wdata;
  end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs with hand-computed results for the cpu pipeline
module tb_cpu;
  import cpu_pkg::*;
  logic clk, rst;
  int n_vec, n_err, n_stall, n_flush, n_branch;
  logic [31:0] prog[$];
  cpu_if bus();
  cpu dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:1] half, input logic [4:0] rs2, input logic [4:0] rs1);
    return {half[12], half[10:5], rs2, rs1, 3'b000, half[4:1], half[11], 7'b1100011};
  endfunction
  task automatic restart();
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < IMEM_WORDS; i++) dut.r_imem[i] = i < prog.size() ? prog[i] : 32'd0;
    for (int i = 0; i < DMEM_WORDS; i++) dut.r_dmem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.r_rf[i] = 32'd0;
    n_stall = 0;
    n_flush = 0;
    n_branch = 0;
    rst = 1'b0;
    bus.start_i = 1'b1;
  endtask
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      n_stall += int'(bus.o_stall);
      n_flush += int'(bus.o_flush);
      n_branch += int'(bus.o_branch);
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.i_imem_we = 1'b0;
    bus.i_imem_addr = '0;
    bus.i_imem_wdata = '0;
    prog = '{enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011)};
    restart();
    check("reset_pc", bus.o_pc, 32'd0);
    check("reset_stall", 32'(bus.o_stall), 32'd0);
    check("reset_flush", 32'(bus.o_flush), 32'd0);
    run(4);
    check("addi_x1_edge4", dut.r_rf[1], 32'd0);
    run(1);
    check("addi_x1_edge5", dut.r_rf[1], 32'd10);
    check("addi_pc_edge5", bus.o_pc, 32'd20);
    prog = '{enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011), enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2)};
    restart();
    run(8);
    check("fwd_x2", dut.r_rf[2], 32'd6);
    check("fwd_stalls", 32'(n_stall), 32'd0);
    prog = '{enc_i(12'd0, 5'd0, 3'b010, 5'd3, 7'b0000011), enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4)};
    restart();
    dut.r_dmem[0] = 32'd5;
    run(8);
    check("lu_x4", dut.r_rf[4], 32'd10);
    check("lu_stalls", 32'(n_stall), 32'd1);
    prog = '{enc_i(12'hFF0, 5'd0, 3'b000, 5'd1, 7'b0010011), enc_s(12'd4, 5'd1, 5'd0),
             enc_i(12'd4, 5'd0, 3'b010, 5'd7, 7'b0000011), enc_i({7'b0100000, 5'd2}, 5'd7, 3'b101, 5'd8, 7'b0010011)};
    restart();
    run(10);
    check("sw_dmem1", dut.r_dmem[1], 32'hFFFFFFF0);
    check("lw_x7", dut.r_rf[7], 32'hFFFFFFF0);
    check("srai_x8", dut.r_rf[8], 32'hFFFFFFFC);
    check("srai_stalls", 32'(n_stall), 32'd1);
    prog = '{enc_r(7'd0, 5'd2, 5'd1, 3'b111, 5'd3), enc_r(7'd0, 5'd2, 5'd1, 3'b100, 5'd4),
             enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd5), enc_r(7'd0, 5'd10, 5'd1, 3'b001, 5'd6)};
    restart();
    dut.r_rf[1] = 32'h0F0F;
    dut.r_rf[2] = 32'h00FF;
    dut.r_rf[10] = 32'd4;
    run(9);
    check("and_x3", dut.r_rf[3], 32'h000F);
    check("xor_x4", dut.r_rf[4], 32'h0FF0);
    check("sub_x5", dut.r_rf[5], 32'h0E10);
    check("sll_x6", dut.r_rf[6], 32'hF0F0);
    prog = '{enc_b(12'd4, 5'd0, 5'd0), enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011),
             enc_i(12'd9, 5'd0, 3'b000, 5'd6, 7'b0010011)};
    restart();
    run(2);
    check("beq_taken_pc", bus.o_pc, 32'd8);
    check("beq_taken_flush", 32'(n_flush), 32'd1);
    run(6);
    check("beq_x5_skipped", dut.r_rf[5], 32'd0);
    check("beq_x6", dut.r_rf[6], 32'd9);
    prog = '{enc_i(12'd1, 5'd0, 3'b000, 5'd1, 7'b0010011), enc_b(12'd4, 5'd0, 5'd1)};
    restart();
    run(4);
    check("beq_nt_pc", bus.o_pc, 32'd12);
    check("beq_nt_flush", 32'(n_flush), 32'd0);
    check("beq_nt_branch", 32'(n_branch), 32'd2);
    check("beq_nt_lu", 32'(n_stall), 32'd0);
    run(4);
    check("beq_nt_x1", dut.r_rf[1], 32'd1);
    prog = '{enc_i(12'd8, 5'd0, 3'b010, 5'd9, 7'b0000011), enc_b(12'd4, 5'd0, 5'd9),
             enc_i(12'd1, 5'd0, 3'b000, 5'd10, 7'b0010011), enc_i(12'd2, 5'd0, 3'b000, 5'd11, 7'b0010011)};
    restart();
    run(12);
    check("beq_lw_x10", dut.r_rf[10], 32'd0);
    check("beq_lw_x11", dut.r_rf[11], 32'd2);
    check("beq_lw_lu", 32'(n_stall), 32'd0);
    check("beq_lw_flush", 32'(n_flush), 32'd1);
    check("beq_lw_branch", 32'(n_branch), 32'd3);
    prog = '{enc_i(12'd10, 5'd0, 3'b000, 5'd1, 7'b0010011)};
    restart();
    bus.start_i = 1'b0;
    run(5);
    check("idle_pc", bus.o_pc, 32'd0);
    check("idle_x1", dut.r_rf[1], 32'd0);
    restart();
    run(4);
    rst = 1'b1;
    run(2);
    check("midrst_x1", dut.r_rf[1], 32'd0);
    check("midrst_pc", bus.o_pc, 32'd0);
    prog = '{enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3)};
    restart();
    dut.r_rf[1] = 32'd6;
    dut.r_rf[2] = 32'd7;
    dut.r_rf[3] = 32'h33;
    run(7);
`ifdef CPU_MUL_EN
    check("mul_x3", dut.r_rf[3], 32'd42);
`else
    check("mul_off_x3", dut.r_rf[3], 32'h33);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
